// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: prefix bytes, framing states, key event payload.
package ps2_pkg;

    localparam logic [7:0]  PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PFX_BRK = 8'hF0;
    localparam int unsigned PS2_EVT_W   = 10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead event FIFO; drops pushes when full and latches a sticky overflow flag.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             iCLK_50,
    input  logic             iRST_n,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPush_data,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    input  logic             iClr_ovf,
    output logic             oOverflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic pop_c;
    logic full_c;
    logic push_ok_c;

    assign pop_c     = (count_q != '0) && iReady;
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign push_ok_c = iPush && (!full_c || pop_c);

    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
            // A drop in the same cycle as a clear request keeps the flag set.
            if (iPush && full_c && !pop_c) ovf_q <= 1'b1;
            else if (iClr_ovf)             ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST_n && push_ok_c) mem[wr_ptr_q] <= iPush_data;
    end

    assign oValid    = (count_q != '0);
    assign oData     = oValid ? mem[rd_ptr_q] : '0;
    assign oOverflow = ovf_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver in the iCLK_50 domain: sync, glitch filter, frame check, E0/F0 decode, event FIFO.
// Optional PS2_LAST_KEY_EN adds oKeycode, the most recent held key for single-key consumers.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       iCLK_50,
    input  logic       iRST_n,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       oEvt_valid,
    input  logic       iEvt_ready,
    output logic [7:0] oEvt_code,
    output logic       oEvt_ext,
    output logic       oEvt_brk,
    output logic       oFrame_err,
    output logic       oOverflow,
`ifdef PS2_LAST_KEY_EN
    output logic [7:0] oKeycode,
`endif
    input  logic       iClr_ovf
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]             line_raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [7:0]             fcnt_q [2];
    logic [1:0]             filt_q;
    logic                   clk_prev_q;
    logic                   strobe_c;
    logic                   dat_f;

    assign line_raw = {PS2_DAT, PS2_CLK};

    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                fcnt_q[i] <= '0;
            end
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], line_raw[i]};
                if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == 8'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i][SYNC_STAGES-1];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 8'd1;
                end
            end
            clk_prev_q <= filt_q[0];
        end
    end

    assign strobe_c = clk_prev_q && !filt_q[0];
    assign dat_f    = filt_q[1];

    ps2_state_e       state_q, state_n;
    logic [2:0]       bit_cnt_q, bit_cnt_n;
    logic [7:0]       shift_q, shift_n;
    logic             par_q, par_n;
    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic             ext_q, ext_n;
    logic             brk_q, brk_n;
    logic             err_q, err_n;
    logic             push_q, push_n;
    ps2_evt_t         evt_q, evt_n;

    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            err_q     <= 1'b0;
            push_q    <= 1'b0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shift_q   <= shift_n;
            par_q     <= par_n;
            tmo_q     <= tmo_n;
            ext_q     <= ext_n;
            brk_q     <= brk_n;
            err_q     <= err_n;
            push_q    <= push_n;
            evt_q     <= evt_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
        par_n     = par_q;
        tmo_n     = '0;
        ext_n     = ext_q;
        brk_n     = brk_q;
        err_n     = 1'b0;
        push_n    = 1'b0;
        evt_n     = evt_q;

        if (state_q != IDLE && !strobe_c) tmo_n = tmo_q + TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (strobe_c && !dat_f) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (strobe_c) begin
                    shift_n   = {dat_f, shift_q[7:1]};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (strobe_c) begin
                    par_n   = dat_f;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (strobe_c) begin
                    state_n = IDLE;
                    if (dat_f && ((^shift_q) ^ par_q)) begin
                        if (shift_q == PS2_PFX_EXT) begin
                            ext_n = 1'b1;
                        end else if (shift_q == PS2_PFX_BRK) begin
                            brk_n = 1'b1;
                        end else begin
                            push_n = 1'b1;
                            evt_n  = '{ext: ext_q, brk: brk_q, code: shift_q};
                            ext_n  = 1'b0;
                            brk_n  = 1'b0;
                        end
                    end else begin
                        err_n = 1'b1;
                        ext_n = 1'b0;
                        brk_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled frame is abandoned and any pending prefix is forgotten.
        if (state_q != IDLE && !strobe_c && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            err_n   = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
        end
    end

    ps2_evt_t head_c;
    logic [PS2_EVT_W-1:0] head_bits_c;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .iCLK_50    (iCLK_50),
        .iRST_n     (iRST_n),
        .iPush      (push_q),
        .iPush_data (evt_q),
        .oValid     (oEvt_valid),
        .iReady     (iEvt_ready),
        .oData      (head_bits_c),
        .iClr_ovf   (iClr_ovf),
        .oOverflow  (oOverflow)
    );

    assign head_c     = head_bits_c;
    assign oEvt_code  = head_c.code;
    assign oEvt_ext   = head_c.ext;
    assign oEvt_brk   = head_c.brk;
    assign oFrame_err = err_q;

`ifdef PS2_LAST_KEY_EN
    always_ff @(posedge iCLK_50) begin
        if (!iRST_n) begin
            oKeycode <= '0;
        end else if (push_q) begin
            if (!evt_q.brk)                  oKeycode <= evt_q.code;
            else if (evt_q.code == oKeycode) oKeycode <= '0;
        end
    end
`endif

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- Parametrised PS/2 keyboard receiver running entirely in the iCLK_50 domain; it replaces the divided-clock, edge-clocked keycode capture.
- Oversamples PS2_CLK/PS2_DAT, glitch-filters them, and frames 11-bit packets with full start/parity/stop checking and an inter-bit timeout.
- Decodes E0/F0 prefixes into key events {ext, brk, code} and buffers them in a ready/valid FIFO for the synth voice allocator.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64.
- SYNC_STAGES, 2, synchroniser flops per line; minimum 2.
- FILTER_LEN, 8, consecutive equal samples before a filtered line changes; 1..255.
- TIMEOUT_CYC, 10000, iCLK_50 cycles without a falling edge before a frame aborts (200 us at 50 MHz).

Ports:
- iCLK_50 input 1 system clock, 50 MHz.
- iRST_n input 1 reset; synchronous, active-low.
- PS2_CLK inout 1 PS/2 clock; never driven (held high-Z), receive only.
- PS2_DAT inout 1 PS/2 data; never driven (held high-Z).
- oEvt_valid output 1 FIFO non-empty; head event presented.
- iEvt_ready input 1 consumer accepts head event.
- oEvt_code output 8 scan code of head event.
- oEvt_ext output 1 head event was E0-prefixed.
- oEvt_brk output 1 head event was F0-prefixed (key release).
- oFrame_err output 1 one-cycle pulse on any rejected frame.
- oOverflow output 1 sticky; set when an event is dropped because the FIFO is full.
- iClr_ovf input 1 clears oOverflow; a same-cycle set wins.

Behaviour:
- Reset (iRST_n low at a clock edge): FSM to IDLE, FIFO flushed, prefix flags cleared, filters preset to 1, all outputs 0. Reset mid-frame discards the partial frame and does not pulse oFrame_err.
- Sync: SYNC_STAGES flops per line. Filter: a filtered line takes a new value after FILTER_LEN consecutive identical synced samples.
- Bit strobe: a 1-to-0 transition of the filtered clock samples the filtered data.
- FSM IDLE: a strobe with data=0 goes to DATA with bit_cnt=0. A strobe with data=1 is ignored and no error is raised.
- FSM DATA: shift in LSB first. After 8 strobes go to PARITY.
- FSM PARITY: the sampled bit is stored. Go to STOP.
- FSM STOP: stop=1 and odd parity (XOR of data and parity = 1) accepts the byte. Otherwise oFrame_err pulses. Either way return to IDLE.
- Timeout: the counter resets on every strobe and runs while not in IDLE. Reaching TIMEOUT_CYC aborts to IDLE, pulses oFrame_err and clears the prefix flags.
- Any frame error clears ext/brk flags.
- Decode of an accepted byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - Push occurs on the cycle after the STOP strobe.
  - Accepted byte to oEvt_valid rising on an empty FIFO: 2 cycles.
- FIFO: show-ahead; oEvt_* are stable while oEvt_valid=1 and not popped. A pop occurs when oEvt_valid and iEvt_ready are both high. Pointers wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits.
- FIFO full: a push without a same-cycle pop is dropped and sets oOverflow. A simultaneous push and pop when full is accepted, and the count is unchanged.
- FIFO empty: iEvt_ready is ignored. A simultaneous push and pop when empty cannot occur because valid=0.

Optional Feature:
- Macro PS2_LAST_KEY_EN.
- Defined: adds output oKeycode[7:0], reset 0.
  - Loads the code on each non-break event push.
  - Clears to 0 on a break event whose code equals oKeycode.
  - Provides legacy single-key compatibility.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- ps2_pkg:
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
  - State enum {IDLE, DATA, PARITY, STOP}.
  - Event width constant PS2_EVT_W=10 and a packed event type {ext, brk, code}.
- Sub-module ps2_evt_fifo: parametrised synchronous show-ahead FIFO (DEPTH, WIDTH) with full/empty/count, push-drop and overflow flag.

Test Plan:
- Make A: frame start0, data 0x1C LSB-first, parity 0, stop1, at 80 us bit period -> one event code=0x1C ext=0 brk=0, no oFrame_err.
- Extended break up-arrow: bytes E0, F0, 75 (parities 0,1,0) -> single event code=0x75 ext=1 brk=1; E0/F0 produce no events.
- Bad parity: 0x1C with parity bit 1 -> oFrame_err pulses once, no event, and a following valid 0x1C is reported normally.
- Timeout: stop the clock after 4 data bits for more than 200 us -> oFrame_err pulse, FSM IDLE, and a following F0,1C yields brk=1 code=0x1C with no stale prefix.
- Overflow: iEvt_ready=0, send 9 makes (0x15..0x1D) -> 8 events held (0x15 first), oOverflow=1. iClr_ovf clears it. Draining gives 0x15..0x1C in order.
- Glitch/reset: a 3-cycle low pulse on PS2_CLK -> no strobe, no error. Asserting iRST_n low mid-frame -> FIFO empty, no error pulse, and the next frame decodes correctly.
